im2col_sequencer: RTL and testbench

Layer-level controller for the IM2COL block. Accepts one layer descriptor per command and programs the IM2COL parameters with a one-cycle set pulse. Streams the input image from the feature RAM into IM2COL while IM2COL requests data, then issues one start-MAC pulse per slice and waits for each slice's done. Sits between the NPU command front-end and the IM2COL block / feature RAM.

---
 rtl/im2col_sequencer.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_im2col_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/im2col_sequencer.sv
// ---------------------------------------------------------------------------
// im2col_sequencer
//
// Purpose: layer-level controller for the IM2COL block. Accepts one layer
// descriptor per command, pulses the IM2COL parameter load, streams the input
// image from the feature RAM into IM2COL while it requests data, then runs one
// start-MAC / done handshake per slice.
//
// Build option:
//   SEQ_TIMEOUT_EN  when defined, a watchdog returns the controller to IDLE
//                   with an o_err pulse if FETCH, DRAIN, WAIT_READY or RUN
//                   makes no progress for TIMEOUT_CYCLES cycles. When not
//                   defined the controller waits indefinitely.
//
// Ports:
//   i_clk, i_reset            clock (rising edge), async active-high reset
//   i_cmd_*, o_cmd_ready      layer command handshake and descriptor fields
//   o_set_param, o_mode_conv,
//   o_image_*, o_slice_*      parameter load pulse and latched descriptor
//   i_en_ram                  IM2COL requests image data
//   o_ram_en, o_ram_addr,
//   i_ram_data                feature-RAM read port
//   o_i2c_valid, o_i2c_data   pixel stream to IM2COL
//   o_ram_read_done           whole image delivered
//   i_image_ready             IM2COL holds the full image
//   o_start_mac, i_done       per-slice start pulse / completion
//   o_busy, o_slice_count,
//   o_layer_done, o_err       status
//
// RAM timing: i_ram_data for a read strobed in cycle t is sampled on the
// RAM_LATENCY-th rising edge counted from the edge that ends cycle t, which
// is the same edge that raises o_i2c_valid for that read. ADDR_WIDTH must not
// exceed 24 (the image-size counter width).
//
// States:
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | ready for a command
//   CONFIG     | o_set_param pulse
//   FETCH      | issuing RAM reads while i_en_ram is high
//   DRAIN      | waiting for in-flight reads, then for i_en_ram to drop
//   WAIT_READY | waiting for IM2COL to report the image loaded
//   START      | o_start_mac pulse for the next slice
//   RUN        | waiting for the slice's i_done
//   DONE       | o_layer_done pulse
// ---------------------------------------------------------------------------
module im2col_sequencer #(
  parameter int DATA_SIZE      = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int RAM_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] i_cmd_base_addr,
  input  logic                  i_cmd_mode_conv,
  input  logic [7:0]            i_cmd_image_width,
  input  logic [7:0]            i_cmd_image_height,
  input  logic [7:0]            i_cmd_image_channel,
  input  logic [7:0]            i_cmd_slice_width,
  input  logic [7:0]            i_cmd_slice_height,
  input  logic [7:0]            i_cmd_slice_number,
  output logic                  o_set_param,
  output logic                  o_mode_conv,
  output logic [7:0]            o_image_width,
  output logic [7:0]            o_image_height,
  output logic [7:0]            o_image_channel,
  output logic [7:0]            o_slice_width,
  output logic [7:0]            o_slice_height,
  output logic [7:0]            o_slice_number,
  input  logic                  i_en_ram,
  output logic                  o_ram_read_done,
  output logic [DATA_SIZE-1:0]  o_i2c_data,
  output logic                  o_i2c_valid,
  output logic                  o_ram_en,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [DATA_SIZE-1:0]  i_ram_data,
  input  logic                  i_image_ready,
  output logic                  o_start_mac,
  input  logic                  i_done,
  output logic                  o_busy,
  output logic [7:0]            o_slice_count,
  output logic                  o_layer_done,
  output logic                  o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_FETCH, S_DRAIN, S_WAIT_READY, S_START, S_RUN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  mode_conv_q, mode_conv_d;
  logic [7:0]            img_w_q, img_w_d, img_h_q, img_h_d, img_c_q, img_c_d;
  logic [7:0]            slc_w_q, slc_w_d, slc_h_q, slc_h_d, slc_n_q, slc_n_d;
  logic [23:0]           total_q, total_d;
  logic [23:0]           issued_q, issued_d;
  logic [23:0]           delivered_q, delivered_d;
  logic [7:0]            slice_cnt_q, slice_cnt_d;

  logic cmd_ready_q, cmd_ready_d;
  logic busy_q, busy_d;
  logic set_param_q, set_param_d;
  logic read_done_q, read_done_d;
  logic start_mac_q, start_mac_d;
  logic layer_done_q, layer_done_d;
  logic err_q, err_d;

  // Read-valid shift register; vcat[k] is the strobe of a read issued k cycles
  // ago, so vcat[RAM_LATENCY] marks the beat presented on o_i2c_valid.
  logic [RAM_LATENCY-1:0] vpipe_q;
  logic [RAM_LATENCY:0]   vcat;
  logic [DATA_SIZE-1:0]   i2c_data_q;

  logic        ram_en;
  logic [23:0] cmd_total;
  logic [8:0]  slice_max;
  logic [8:0]  slice_next;

`ifdef SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timed_state;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  assign cmd_total  = 24'(i_cmd_image_width) * 24'(i_cmd_image_height) * 24'(i_cmd_image_channel);
  assign ram_en     = (state_q == S_FETCH) && i_en_ram && (issued_q != total_q);
  assign vcat       = {vpipe_q, ram_en};
  assign slice_max  = (slc_n_q == 8'd0) ? 9'd1 : {1'b0, slc_n_q};
  assign slice_next = {1'b0, slice_cnt_q} + 9'd1;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    mode_conv_d = mode_conv_q;
    img_w_d     = img_w_q;
    img_h_d     = img_h_q;
    img_c_d     = img_c_q;
    slc_w_d     = slc_w_q;
    slc_h_d     = slc_h_q;
    slc_n_d     = slc_n_q;
    total_d     = total_q;
    issued_d    = ram_en ? issued_q + 24'd1 : issued_q;
    delivered_d = vcat[RAM_LATENCY] ? delivered_q + 24'd1 : delivered_q;
    slice_cnt_d = slice_cnt_q;
    err_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          if (cmd_total == 24'd0) begin
            err_d = 1'b1;
          end else begin
            base_d      = i_cmd_base_addr;
            mode_conv_d = i_cmd_mode_conv;
            img_w_d     = i_cmd_image_width;
            img_h_d     = i_cmd_image_height;
            img_c_d     = i_cmd_image_channel;
            slc_w_d     = i_cmd_slice_width;
            slc_h_d     = i_cmd_slice_height;
            slc_n_d     = i_cmd_slice_number;
            total_d     = cmd_total;
            issued_d    = 24'd0;
            delivered_d = 24'd0;
            slice_cnt_d = 8'd0;
            state_d     = S_CONFIG;
          end
        end
      end
      S_CONFIG:     state_d = S_FETCH;
      S_FETCH:      if (issued_d == total_q) state_d = S_DRAIN;
      S_DRAIN:      if ((delivered_q == total_q) && !i_en_ram) state_d = S_WAIT_READY;
      S_WAIT_READY: if (i_image_ready) state_d = S_START;
      S_START:      state_d = S_RUN;
      S_RUN: begin
        if (i_done) begin
          slice_cnt_d = slice_next[7:0];
          state_d     = (slice_next < slice_max) ? S_START : S_DONE;
        end
      end
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

`ifdef SEQ_TIMEOUT_EN
    // Only a stalled state times out; any transition or read beat restarts it.
    timed_state = (state_q == S_FETCH) || (state_q == S_DRAIN) ||
                  (state_q == S_WAIT_READY) || (state_q == S_RUN);
    if (timed_state && (state_d == state_q) && !ram_en &&
        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
    if ((state_d != state_q) || ram_en || !timed_state) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
`endif

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    cmd_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    set_param_d  = (state_d == S_CONFIG);
    start_mac_d  = (state_d == S_START);
    layer_done_d = (state_d == S_DONE);
    read_done_d  = (state_d == S_DRAIN) && (delivered_d == total_q);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      mode_conv_q  <= 1'b0;
      img_w_q      <= 8'd0;
      img_h_q      <= 8'd0;
      img_c_q      <= 8'd0;
      slc_w_q      <= 8'd0;
      slc_h_q      <= 8'd0;
      slc_n_q      <= 8'd0;
      total_q      <= 24'd0;
      issued_q     <= 24'd0;
      delivered_q  <= 24'd0;
      slice_cnt_q  <= 8'd0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      set_param_q  <= 1'b0;
      read_done_q  <= 1'b0;
      start_mac_q  <= 1'b0;
      layer_done_q <= 1'b0;
      err_q        <= 1'b0;
      vpipe_q      <= '0;
      i2c_data_q   <= '0;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      mode_conv_q  <= mode_conv_d;
      img_w_q      <= img_w_d;
      img_h_q      <= img_h_d;
      img_c_q      <= img_c_d;
      slc_w_q      <= slc_w_d;
      slc_h_q      <= slc_h_d;
      slc_n_q      <= slc_n_d;
      total_q      <= total_d;
      issued_q     <= issued_d;
      delivered_q  <= delivered_d;
      slice_cnt_q  <= slice_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      set_param_q  <= set_param_d;
      read_done_q  <= read_done_d;
      start_mac_q  <= start_mac_d;
      layer_done_q <= layer_done_d;
      err_q        <= err_d;
      vpipe_q      <= vcat[RAM_LATENCY-1:0];
      // Capture RAM data on the same edge that raises the matching valid.
      if (vcat[RAM_LATENCY-1]) i2c_data_q <= i_ram_data;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign o_cmd_ready     = cmd_ready_q;
  assign o_busy          = busy_q;
  assign o_set_param     = set_param_q;
  assign o_ram_read_done = read_done_q;
  assign o_start_mac     = start_mac_q;
  assign o_layer_done    = layer_done_q;
  assign o_err           = err_q;
  assign o_slice_count   = slice_cnt_q;
  assign o_mode_conv     = mode_conv_q;
  assign o_image_width   = img_w_q;
  assign o_image_height  = img_h_q;
  assign o_image_channel = img_c_q;
  assign o_slice_width   = slc_w_q;
  assign o_slice_height  = slc_h_q;
  assign o_slice_number  = slc_n_q;
  assign o_ram_en        = ram_en;
  assign o_ram_addr      = base_q + issued_q[ADDR_WIDTH-1:0];
  assign o_i2c_valid     = vpipe_q[RAM_LATENCY-1];
  assign o_i2c_data      = i2c_data_q;

endmodule

// File: tb/tb_im2col_sequencer.sv
module tb_im2col_sequencer;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [AW-1:0] i_cmd_base_addr;
  logic          i_cmd_mode_conv;
  logic [7:0]    i_cmd_image_width, i_cmd_image_height, i_cmd_image_channel;
  logic [7:0]    i_cmd_slice_width, i_cmd_slice_height, i_cmd_slice_number;
  logic          o_set_param, o_mode_conv;
  logic [7:0]    o_image_width, o_image_height, o_image_channel;
  logic [7:0]    o_slice_width, o_slice_height, o_slice_number;
  logic          i_en_ram, o_ram_read_done;
  logic [DW-1:0] o_i2c_data;
  logic          o_i2c_valid, o_ram_en;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] i_ram_data;
  logic          i_image_ready, o_start_mac, i_done, o_busy;
  logic [7:0]    o_slice_count;
  logic          o_layer_done, o_err;

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] pix(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // RAM_LATENCY = 1: data is sampled on the edge ending the strobe cycle.
  assign i_ram_data = pix(o_ram_addr);

  im2col_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_base_addr(i_cmd_base_addr), .i_cmd_mode_conv(i_cmd_mode_conv),
    .i_cmd_image_width(i_cmd_image_width), .i_cmd_image_height(i_cmd_image_height),
    .i_cmd_image_channel(i_cmd_image_channel), .i_cmd_slice_width(i_cmd_slice_width),
    .i_cmd_slice_height(i_cmd_slice_height), .i_cmd_slice_number(i_cmd_slice_number),
    .o_set_param(o_set_param), .o_mode_conv(o_mode_conv),
    .o_image_width(o_image_width), .o_image_height(o_image_height),
    .o_image_channel(o_image_channel), .o_slice_width(o_slice_width),
    .o_slice_height(o_slice_height), .o_slice_number(o_slice_number),
    .i_en_ram(i_en_ram), .o_ram_read_done(o_ram_read_done),
    .o_i2c_data(o_i2c_data), .o_i2c_valid(o_i2c_valid),
    .o_ram_en(o_ram_en), .o_ram_addr(o_ram_addr), .i_ram_data(i_ram_data),
    .i_image_ready(i_image_ready), .o_start_mac(o_start_mac), .i_done(i_done),
    .o_busy(o_busy), .o_slice_count(o_slice_count),
    .o_layer_done(o_layer_done), .o_err(o_err)
  );

  int n_vec, n_bad;
  int n_set, n_reads, n_valid, n_start, n_done, n_layer, n_err, n_rd_done;
  int en_viol, first_rd, last_rd, first_vl, rdy_after;
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one command and runs it until o_layer_done/o_err plus three tail
  // cycles. en_mode 0 holds i_en_ram high, 1 toggles it. abort_at > 0 asserts
  // i_reset once that many reads have been issued.
  task automatic run_cmd(input logic [AW-1:0] base, input logic [7:0] w, input logic [7:0] h,
                         input logic [7:0] c, input logic [7:0] sn, input int en_mode,
                         input int abort_at, output bit aborted);
    int tail;
    int done_cd;
    n_set = 0; n_reads = 0; n_valid = 0; n_start = 0; n_done = 0; n_layer = 0;
    n_err = 0; n_rd_done = 0; en_viol = 0; first_rd = 0; last_rd = 0; first_vl = 0;
    rdy_after = 0;
    addr_q.delete();
    data_q.delete();
    aborted = 1'b0;
    @(negedge i_clk);
    i_cmd_base_addr     = base;
    i_cmd_image_width   = w;
    i_cmd_image_height  = h;
    i_cmd_image_channel = c;
    i_cmd_slice_width   = 8'd2;
    i_cmd_slice_height  = 8'd2;
    i_cmd_slice_number  = sn;
    i_cmd_mode_conv     = 1'b1;
    i_cmd_valid         = 1'b1;
    #1 chk("cmd_ready_pre", o_cmd_ready, 1);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    tail = -1;
    done_cd = -1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) @(negedge i_clk);
      if (abort_at > 0 && n_reads == abort_at) begin
        i_reset = 1'b1;
        #1;
        chk("rst_mid_busy", o_busy, 0);
        chk("rst_mid_ram_en", o_ram_en, 0);
        chk("rst_mid_valid", o_i2c_valid, 0);
        chk("rst_mid_ready", o_cmd_ready, 0);
        aborted = 1'b1;
        break;
      end
      if (n_rd_done > 0) i_en_ram = 1'b0;
      else i_en_ram = (en_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      i_done = (done_cd == 0);
      if (done_cd >= 0) done_cd--;
      #1;
      if (o_set_param) n_set++;
      if (o_ram_en) begin
        if (!i_en_ram) en_viol++;
        if (n_reads == 0) first_rd = cyc;
        last_rd = cyc;
        n_reads++;
        addr_q.push_back(o_ram_addr);
      end
      if (o_i2c_valid) begin
        if (n_valid == 0) first_vl = cyc;
        n_valid++;
        data_q.push_back(o_i2c_data);
      end
      if (o_ram_read_done) n_rd_done++;
      if (o_start_mac) begin
        n_start++;
        done_cd = 2;
      end
      if (i_done) n_done++;
      if (o_layer_done) n_layer++;
      if (o_err) n_err++;
      if (tail > 0) begin
        if (tail == 3) rdy_after = o_cmd_ready;
        tail--;
        if (tail == 0) break;
      end else if (tail < 0 && (o_layer_done || o_err)) begin
        tail = 3;
      end
    end
    i_en_ram = 1'b0;
    i_done   = 1'b0;
    if (!aborted) chk("run_bounded", tail, 0);
  endtask

  task automatic chk_stream(input logic [AW-1:0] base, input int n);
    int abad;
    int dbad;
    abad = 0;
    dbad = 0;
    chk("n_reads", n_reads, n);
    chk("n_valid", n_valid, n);
    foreach (addr_q[i]) if (addr_q[i] !== AW'(base + i)) abad++;
    foreach (data_q[i]) if (data_q[i] !== pix(AW'(base + i))) dbad++;
    chk("addr_order", abad, 0);
    chk("data_order", dbad, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ab;
    int stray;
    n_vec = 0; n_bad = 0;
    i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_base_addr = '0; i_cmd_mode_conv = 1'b0;
    i_cmd_image_width = 8'd0; i_cmd_image_height = 8'd0; i_cmd_image_channel = 8'd0;
    i_cmd_slice_width = 8'd0; i_cmd_slice_height = 8'd0; i_cmd_slice_number = 8'd0;
    i_en_ram = 1'b0; i_image_ready = 1'b1; i_done = 1'b0;

    // reset state
    repeat (3) @(negedge i_clk);
    chk("rst_ready", o_cmd_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_addr", o_ram_addr, 0);
    chk("rst_count", o_slice_count, 0);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("idle_ready", o_cmd_ready, 1);
    chk("idle_busy", o_busy, 0);

    // 4x4x1 at 0x010, 3 slices, i_en_ram held high
    run_cmd(12'h010, 8'd4, 8'd4, 8'd1, 8'd3, 0, 0, ab);
    chk_stream(12'h010, 16);
    chk("t1_set_param", n_set, 1);
    chk("t1_read_span", last_rd - first_rd, 15);
    chk("t1_latency", first_vl - first_rd, 1);
    chk("t1_read_done", n_rd_done > 0, 1);
    chk("t1_start_mac", n_start, 3);
    chk("t1_done_in", n_done, 3);
    chk("t1_slice_count", o_slice_count, 3);
    chk("t1_layer_done", n_layer, 1);
    chk("t1_err", n_err, 0);
    chk("t1_ready_after", rdy_after, 1);
    chk("t1_busy_end", o_busy, 0);
    chk("t1_img_w", o_image_width, 4);
    chk("t1_slice_n", o_slice_number, 3);

    // same command, i_en_ram toggling
    run_cmd(12'h010, 8'd4, 8'd4, 8'd1, 8'd3, 1, 0, ab);
    chk_stream(12'h010, 16);
    chk("t2_en_viol", en_viol, 0);
    chk("t2_read_span", last_rd - first_rd, 30);
    chk("t2_start_mac", n_start, 3);
    chk("t2_layer_done", n_layer, 1);

    // zero width: rejected
    run_cmd(12'h100, 8'd0, 8'd4, 8'd1, 8'd2, 0, 0, ab);
    chk("t3_err", n_err, 1);
    chk("t3_set_param", n_set, 0);
    chk("t3_reads", n_reads, 0);
    chk("t3_ready_after", rdy_after, 1);
    chk("t3_layer_done", n_layer, 0);
    chk("t3_count_held", o_slice_count, 3);

    // address wrap, slice_number 0 treated as 1
    run_cmd(12'hFFE, 8'd2, 8'd2, 8'd1, 8'd0, 0, 0, ab);
    chk_stream(12'hFFE, 4);
    chk("t4_start_mac", n_start, 1);
    chk("t4_slice_count", o_slice_count, 1);
    chk("t4_layer_done", n_layer, 1);

    // reset after 5 reads, then a fresh layer
    run_cmd(12'h010, 8'd4, 8'd4, 8'd1, 8'd3, 0, 5, ab);
    chk("t5_aborted", ab, 1);
    stray = 0;
    repeat (2) begin
      @(negedge i_clk);
      #1 if (o_i2c_valid) stray++;
    end
    i_reset = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      #1 if (o_i2c_valid) stray++;
    end
    chk("t5_stray_valid", stray, 0);
    chk("t5_img_w_clr", o_image_width, 0);
    chk("t5_count_clr", o_slice_count, 0);
    chk("t5_ready", o_cmd_ready, 1);
    run_cmd(12'h020, 8'd2, 8'd2, 8'd1, 8'd2, 0, 0, ab);
    chk_stream(12'h020, 4);
    chk("t5_set_param", n_set, 1);
    chk("t5_start_mac", n_start, 2);
    chk("t5_slice_count", o_slice_count, 2);
    chk("t5_layer_done", n_layer, 1);
    chk("t5_err", n_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
